// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the core/debug memory arbiter: sequencer states, port ids,
// and the latency counter width.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        PORT_C = 1'b0,
        PORT_D = 1'b1
    } port_e;

    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin pick: a lone requester wins; on a tie the port that did not
// own the previous transfer wins. Purely combinational, one-hot output {D, C}.
module mem_arb_rr
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  port_e      last_owner_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (last_owner_i == PORT_D) ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single-port unified memory between the core (C) and the debug
// loader (D): grant in IDLE, one mem_en strobe, fixed-latency wait, one ack pulse.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                c_req,
    input  logic                c_we,
    input  logic [ADDR_W-1:0]   c_addr,
    input  logic [DATA_W-1:0]   c_wdata,
    input  logic [DATA_W/8-1:0] c_wstrb,
    output logic                c_gnt,
    output logic                c_ack,
    output logic [DATA_W-1:0]   c_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic                d_gnt,
    output logic                d_ack,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int STRB_W = DATA_W / 8;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    arb_state_e          state_q, state_d;
    port_e               owner_q, owner_d;
    port_e               last_owner_q, last_owner_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   c_rdata_q, c_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

    logic [1:0] pick;
    logic [1:0] gnt_vec;
    logic       drive_mem;
    logic       sel_d;

    mem_arb_rr u_rr (
        .req_i        ({d_req, c_req}),
        .last_owner_i (last_owner_q),
        .gnt_o        (pick)
    );

    // Grants are gated by rstn so they also drop immediately while reset is held.
    assign gnt_vec = (state_q == ST_IDLE && rstn) ? pick : 2'b00;
    assign c_gnt   = gnt_vec[0];
    assign d_gnt   = gnt_vec[1];
    assign sel_d   = gnt_vec[1];

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        cnt_d        = cnt_q;
        c_rdata_d    = c_rdata_q;
        d_rdata_d    = d_rdata_q;
        mem_en       = 1'b0;
        drive_mem    = 1'b0;
        c_ack        = 1'b0;
        d_ack        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|gnt_vec) begin
                    owner_d = sel_d ? PORT_D : PORT_C;
                    we_d    = sel_d ? d_we    : c_we;
                    addr_d  = sel_d ? d_addr  : c_addr;
                    wdata_d = sel_d ? d_wdata : c_wdata;
                    // Reads present an all-zero strobe to the memory.
                    if (sel_d) wstrb_d = d_we ? d_wstrb : '0;
                    else       wstrb_d = c_we ? c_wstrb : '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mem_en    = 1'b1;
                drive_mem = 1'b1;
                cnt_d     = CNT_LOAD;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                drive_mem = 1'b1;
                if (cnt_q == '0) begin
                    if (!we_q) begin
                        if (owner_q == PORT_D) d_rdata_d = mem_rdata;
                        else                   c_rdata_d = mem_rdata;
                    end
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                c_ack        = (owner_q == PORT_C);
                d_ack        = (owner_q == PORT_D);
                last_owner_d = owner_q;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mem_we    = drive_mem & we_q;
    assign mem_addr  = drive_mem ? (addr_q & ALIGN_MASK) : '0;
    assign mem_wdata = drive_mem ? wdata_q : '0;
    assign mem_wstrb = drive_mem ? wstrb_q : '0;
    assign c_rdata   = c_rdata_q;
    assign d_rdata   = d_rdata_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            owner_q      <= PORT_C;
            last_owner_q <= PORT_D;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            cnt_q        <= '0;
            c_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            cnt_q        <= cnt_d;
            c_rdata_q    <= c_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

endmodule
